seg_write_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of the seven-segment display slave (STB/ACK handshake, 16-bit DAT_I) between N_REQ requesters such as the CPU, the debug unit and the timer. It grants one requester at a time and issues a single write strobe. It then enforces a minimum hold period so each displayed value stays readable before another requester can overwrite it. It sits between the requesters and the display, and drives the display's STB and DAT_I.

---
 rtl/seg_write_arbiter.sv | 171 +++++++++++++++++
 tb/tb_seg_write_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg_write_arbiter
// Purpose  : Round-robin arbiter that shares the seven-segment display write
//            port, holding each written value for a minimum display time.
// Revision : 1.0
// ============================================================================
module seg_write_arbiter #(
    parameter int N_REQ       = 4,
    parameter int MIN_HOLD    = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_stb_i,
    input  logic [16*N_REQ-1:0]  req_dat_i,
    output logic [N_REQ-1:0]     req_ack_o,
    output logic                 m_stb_o,
    output logic [15:0]          m_dat_o,
    input  logic                 m_ack_i,
    output logic [2:0]           grant_id_o,
    output logic                 busy_o,
    output logic                 err_o,
    input  logic                 err_clr_i
);

    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [N_REQ-1:0]   req_ack_q, req_ack_d;
    logic               m_stb_q, m_stb_d;
    logic [15:0]        m_dat_q, m_dat_d;
    logic [2:0]         grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [7:0]         w_req_ext;
    logic [127:0]       w_dat_ext;
    logic [7:0]         w_ack_onehot;
    logic [3:0]         w_idx;
    logic [3:0]         w_nxt;
    logic [2:0]         w_win;
    logic               w_found;
    logic               w_timeout;

    assign w_req_ext    = 8'(req_stb_i);
    assign w_dat_ext    = 128'(req_dat_i);
    assign w_ack_onehot = 8'd1 << grant_q;

    // Search ptr, ptr+1, ... (mod N_REQ); the first active request wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_idx   = 4'd0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, ptr_q} + 4'(k);
            if (w_idx >= 4'(N_REQ)) begin
                w_idx = w_idx - 4'(N_REQ);
            end
            if (!w_found && w_req_ext[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
        w_nxt = {1'b0, w_win} + 4'd1;
        if (w_nxt >= 4'(N_REQ)) begin
            w_nxt = 4'd0;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wait_d    = wait_q;
        hold_d    = hold_q;
        req_ack_d = '0;
        m_stb_d   = m_stb_q;
        m_dat_d   = m_dat_q;
        grant_d   = grant_q;
        w_timeout = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    state_d = S_ISSUE;
                    m_stb_d = 1'b1;
                    m_dat_d = w_dat_ext[{w_win, 4'b0000} +: 16];
                    grant_d = w_win;
                    ptr_d   = w_nxt[2:0];
                    wait_d  = '0;
                end
            end
            S_ISSUE: begin
                // Completion and abort share one exit so the requester is always released.
                if (m_ack_i || (wait_q == WAIT_W'(ACK_TIMEOUT - 1))) begin
                    state_d   = S_HOLD;
                    m_stb_d   = 1'b0;
                    req_ack_d = w_ack_onehot[N_REQ-1:0];
                    hold_d    = HOLD_W'(MIN_HOLD - 1);
                    w_timeout = !m_ack_i;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_d = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (w_timeout) begin
            err_d = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= 3'd0;
            wait_q    <= '0;
            hold_q    <= '0;
            req_ack_q <= '0;
            m_stb_q   <= 1'b0;
            m_dat_q   <= 16'h0000;
            grant_q   <= 3'd0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wait_q    <= wait_d;
            hold_q    <= hold_d;
            req_ack_q <= req_ack_d;
            m_stb_q   <= m_stb_d;
            m_dat_q   <= m_dat_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign req_ack_o  = req_ack_q;
    assign m_stb_o    = m_stb_q;
    assign m_dat_o    = m_dat_q;
    assign grant_id_o = grant_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_write_arbiter
// Purpose  : Directed bench for seg_write_arbiter with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_seg_write_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;
    localparam int AT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_stb = '0;
    logic [63:0] req_dat = '0;
    logic        err_clr = 1'b0;
    logic        ack_mode = 1'b1;
    logic        m_ack;
    logic [3:0]  req_ack;
    logic        m_stb;
    logic [15:0] m_dat;
    logic [2:0]  gid;
    logic        busy;
    logic        err;

    seg_write_arbiter #(.N_REQ(N), .MIN_HOLD(MH), .ACK_TIMEOUT(AT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_stb_i  (req_stb),
        .req_dat_i  (req_dat),
        .req_ack_o  (req_ack),
        .m_stb_o    (m_stb),
        .m_dat_o    (m_dat),
        .m_ack_i    (m_ack),
        .grant_id_o (gid),
        .busy_o     (busy),
        .err_o      (err),
        .err_clr_i  (err_clr)
    );

    // Display that acknowledges in the same cycle as its strobe, or never.
    assign m_ack = ack_mode & m_stb;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: one write transaction = a strobe phase, an ack pulse, then MH display cycles.
    logic        e_stb;
    logic [15:0] e_dat;
    logic [2:0]  e_gid;
    logic [3:0]  e_ack;
    logic        e_busy;
    logic        e_err;
    int          ptr;
    int          strobe_cycles;
    int          hold_left;
    int          cand;
    bit          found;
    bit          timed_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_stb = 0; e_dat = '0; e_gid = '0; e_ack = '0; e_busy = 0; e_err = 0;
            ptr = 0; strobe_cycles = 0; hold_left = 0;
        end else begin
            timed_out = 0;
            e_ack = '0;
            if (!e_busy) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    cand = (ptr + k) % N;
                    if (!found && req_stb[cand]) begin
                        found = 1;
                        e_gid = 3'(cand);
                        e_dat = req_dat[16*cand +: 16];
                        ptr = (cand + 1) % N;
                    end
                end
                if (found) begin
                    e_busy = 1; e_stb = 1; strobe_cycles = 1;
                end
            end else if (e_stb) begin
                if (ack_mode || strobe_cycles == AT) begin
                    e_stb = 0;
                    e_ack[e_gid] = 1'b1;
                    hold_left = MH;
                    timed_out = !ack_mode;
                end else begin
                    strobe_cycles++;
                end
            end else begin
                hold_left--;
                if (hold_left == 0) e_busy = 0;
            end
            if (err_clr) e_err = 0;
            if (timed_out) e_err = 1;
        end
    end

    int          rise_cyc[$];
    logic [2:0]  rise_gid[$];
    logic [15:0] rise_dat[$];
    int          ack3_cnt = 0;
    logic        prev_stb = 1'b0;

    always @(negedge clk) begin
        cyc++;
        chk("m_stb", 32'(m_stb), 32'(e_stb));
        chk("m_dat", 32'(m_dat), 32'(e_dat));
        chk("grant_id", 32'(gid), 32'(e_gid));
        chk("req_ack", 32'(req_ack), 32'(e_ack));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("err", 32'(err), 32'(e_err));
        if (m_stb && !prev_stb) begin
            rise_cyc.push_back(cyc);
            rise_gid.push_back(gid);
            rise_dat.push_back(m_dat);
        end
        if (req_ack[3]) ack3_cnt++;
        prev_stb = m_stb;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rise(input int base, input string name);
        bit ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            step();
            if (rise_cyc.size() > base) ok = 1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_ack(input string name);
        bit ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            step();
            if (req_ack != 4'b0000) ok = 1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            step();
            if (!busy) ok = 1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    logic [15:0] dtab [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    initial begin
        int n;
        int base;
        int a3;
        step();
        chk("rst_m_stb", 32'(m_stb), 32'd0);
        chk("rst_m_dat", 32'(m_dat), 32'h0000);
        chk("rst_grant", 32'(gid), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_busy_err", 32'({busy, err}), 32'd0);
        step();
        rst_n = 1'b1;

        // Single request, same-cycle ack
        req_dat[47:32] = 16'hBEEF;
        req_stb = 4'b0100;
        step();
        chk("t1_stb", 32'(m_stb), 32'd1);
        chk("t1_dat", 32'(m_dat), 32'hBEEF);
        chk("t1_gid", 32'(gid), 32'd2);
        step();
        chk("t1_stb_low", 32'(m_stb), 32'd0);
        chk("t1_ack", 32'(req_ack), 32'b0100);
        chk("t1_gid_hold", 32'(gid), 32'd2);
        req_stb = 4'b0000;
        n = 2;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!busy) break;
            n++;
        end
        chk("t1_busy_len", 32'(n), 32'(MH + 1));

        // Round robin with every requester active, after a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) req_dat[16*i +: 16] = dtab[i];
        req_stb = 4'b1111;
        base = rise_cyc.size();
        for (int g = 0; g < 5; g++) wait_rise(base + g, "t2_grant_timeout");
        req_stb = 4'b0000;
        if (rise_cyc.size() >= base + 5) begin
            for (int g = 0; g < 5; g++) begin
                chk("t2_order", 32'(rise_gid[base+g]), 32'(g % 4));
                chk("t2_data", 32'(rise_dat[base+g]), 32'(dtab[g % 4]));
                if (g > 0) chk("t2_spacing", 32'(rise_cyc[base+g] - rise_cyc[base+g-1]), 32'(MH + 2));
            end
        end
        wait_idle("t2_idle_timeout");

        // Timeout with no display ack
        ack_mode = 1'b0;
        req_stb = 4'b0010;
        wait_rise(rise_cyc.size(), "t3_rise_timeout");
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!m_stb) break;
            n++;
            step();
        end
        chk("t3_stb_len", 32'(n), 32'(AT));
        chk("t3_ack", 32'(req_ack), 32'b0010);
        chk("t3_err_set", 32'(err), 32'd1);
        req_stb = 4'b0000;
        repeat (3) step();
        chk("t3_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t3_err_clr", 32'(err), 32'd0);
        wait_idle("t3_idle_timeout");

        // Timeout coinciding with err_clr
        err_clr = 1'b1;
        req_stb = 4'b0100;
        wait_ack("t4_ack_timeout");
        chk("t4_err_wins", 32'(err), 32'd1);
        req_stb = 4'b0000;
        step();
        err_clr = 1'b0;
        chk("t4_err_cleared", 32'(err), 32'd0);
        wait_idle("t4_idle_timeout");

        // Reset during ISSUE; pointer returns to 0
        req_stb = 4'b1010;
        wait_rise(rise_cyc.size(), "t5_rise_timeout");
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_stb", 32'(m_stb), 32'd0);
        chk("t5_rst_ack", 32'(req_ack), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        step();
        chk("t5_no_ack", 32'(req_ack), 32'd0);
        ack_mode = 1'b1;
        rst_n = 1'b1;
        base = rise_cyc.size();
        wait_rise(base, "t5_regrant_timeout");
        if (rise_gid.size() > base) chk("t5_first_gid", 32'(rise_gid[base]), 32'd1);
        wait_ack("t5_ack1_timeout");
        req_stb = 4'b1000;
        wait_rise(base + 1, "t5_second_timeout");
        if (rise_gid.size() > base + 1) chk("t5_second_gid", 32'(rise_gid[base+1]), 32'd3);
        wait_ack("t5_ack3_timeout");
        req_stb = 4'b0000;
        wait_idle("t5_idle_timeout");

        // Requester 3 withdraws during requester 1's HOLD
        req_stb = 4'b0010;
        wait_ack("t6_ack_timeout");
        req_stb = 4'b1000;
        a3 = ack3_cnt;
        base = rise_cyc.size();
        step();
        step();
        req_stb = 4'b0000;
        repeat (15) step();
        chk("t6_no_grant", 32'(rise_cyc.size() - base), 32'd0);
        chk("t6_no_ack3", 32'(ack3_cnt - a3), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
